// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one ALU between NUM_REQ requesters, round-robin, fixed ALU_LAT.
// Build option `ALU_ARB_PRIO_EN gives requester 0 fixed top priority over the rotation.
//
// state | meaning
// IDLE  | arbitrate, raise req_ready for the winner, latch its operation
// ISSUE | present latched operation to the ALU with alu_inp_valid
// WAIT  | hold operands, count ALU_LAT down, capture result at terminal count
// RESP  | pulse rsp_valid to the granted requester, advance last_grant
module alu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CMD_W   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_inp_valid,
  input  logic [NUM_REQ-1:0]       req_mode,
  input  logic [CMD_W*NUM_REQ-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]       req_cin,
  input  logic [WIDTH*NUM_REQ-1:0] req_opa,
  input  logic [WIDTH*NUM_REQ-1:0] req_opb,
  output logic                     alu_ce,
  output logic [1:0]               alu_inp_valid,
  output logic                     alu_mode,
  output logic [CMD_W-1:0]         alu_cmd,
  output logic                     alu_cin,
  output logic [WIDTH-1:0]         alu_opa,
  output logic [WIDTH-1:0]         alu_opb,
  input  logic [2*WIDTH-1:0]       alu_res,
  input  logic [5:0]               alu_flags,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]       rsp_res,
  output logic [5:0]               rsp_flags,
  output logic                     busy
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  last_grant, grant, grant_lat;
  logic              grant_vld;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        lat_iv;
  logic              lat_mode, lat_cin;
  logic [CMD_W-1:0]  lat_cmd;
  logic [WIDTH-1:0]  lat_opa, lat_opb;

  // Scan downward so the closest requester after last_grant is assigned last and wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    grant     = last_grant;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
`ifdef ALU_ARB_PRIO_EN
    if (req_valid[0]) begin
      grant     = '0;
      grant_vld = 1'b1;
    end
`else
    grant_vld = grant_vld | 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cnt == CNT_W'(1)) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      grant_lat  <= '0;
      cnt        <= '0;
      lat_iv     <= '0;
      lat_mode   <= 1'b0;
      lat_cin    <= 1'b0;
      lat_cmd    <= '0;
      lat_opa    <= '0;
      lat_opb    <= '0;
      rsp_res    <= '0;
      rsp_flags  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            grant_lat <= grant;
            lat_iv    <= req_inp_valid[int'(grant)*2 +: 2];
            lat_mode  <= req_mode[grant];
            lat_cin   <= req_cin[grant];
            lat_cmd   <= req_cmd[int'(grant)*CMD_W +: CMD_W];
            lat_opa   <= req_opa[int'(grant)*WIDTH +: WIDTH];
            lat_opb   <= req_opb[int'(grant)*WIDTH +: WIDTH];
          end
        end
        S_ISSUE: cnt <= CNT_W'(ALU_LAT);
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            rsp_res   <= alu_res;
            rsp_flags <= alu_flags;
          end
        end
        S_RESP: begin
`ifdef ALU_ARB_PRIO_EN
          // Priority grants to requester 0 leave the rotation among the others untouched.
          if (grant_lat != '0) last_grant <= grant_lat;
`else
          last_grant <= grant_lat;
`endif
        end
        default: ;
      endcase
    end
  end

  // rst_n gating keeps req_ready low while reset holds the FSM in IDLE.
  assign req_ready     = (state == S_IDLE && grant_vld && rst_n) ? (NUM_REQ'(1) << grant) : '0;
  assign rsp_valid     = (state == S_RESP) ? (NUM_REQ'(1) << grant_lat) : '0;
  assign busy          = (state != S_IDLE);
  assign alu_ce        = (state == S_ISSUE) || (state == S_WAIT);
  assign alu_inp_valid = (state == S_ISSUE) ? lat_iv : 2'b00;
  assign alu_mode      = lat_mode;
  assign alu_cmd       = lat_cmd;
  assign alu_cin       = lat_cin;
  assign alu_opa       = lat_opa;
  assign alu_opb       = lat_opb;

endmodule
